// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Measures an external PWM waveform and reports its duty in percent
//   (0..100, the same scale as the duty command), plus its period and high
//   time in clock cycles. A stuck line is reported after TIMEOUT edge-free
//   cycles.
//
// Parameters
//   CNT_W    width of the period/high-time counters and outputs
//   TIMEOUT  edge-free cycles before the line is declared stuck (< 2**CNT_W)
//
// Ports
//   CLK       in   system clock, rising edge
//   RST_n     in   asynchronous active-low reset
//   PWM_IN    in   asynchronous PWM input
//   Duty      out  floor(HighTime*100/Period), 0..100
//   Period    out  last rising-to-rising period, in cycles
//   HighTime  out  last high time, in cycles
//   Valid     out  one-cycle pulse when Duty/Period/HighTime update
//   Stuck     out  high while the line has shown no edge for TIMEOUT cycles
//   Overrun   out  sticky: a period completed while the divider was busy
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             PWM_IN,
  output logic [6:0]       Duty,
  output logic [CNT_W-1:0] Period,
  output logic [CNT_W-1:0] HighTime,
  output logic             Valid,
  output logic             Stuck,
  output logic             Overrun
);

  localparam int DIV_W = CNT_W + 7;
  localparam int GAP_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,   // waiting for the first rise
    S_HIGH,   // synchronised line high, counting
    S_LOW     // synchronised line low, counting
  } state_t;

  state_t state, next_state;

  logic             sync1, sync2, sync3;
  logic             rise, fall, edge_seen;
  logic [GAP_W-1:0] gap;
  logic             timeout_evt;
  logic [CNT_W-1:0] cnt, high_cnt;
  logic [CNT_W-1:0] snap_period, snap_high;
  logic             period_done, accept;
  logic             div_busy, div_last, q_bit;
  logic [2:0]       div_iter;
  logic [DIV_W-1:0] rem, dsr;
  logic [6:0]       quo;

  // ---------------------------------------------------------------------------
  // Input synchroniser plus a registered copy for edge detection.
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments make each flop sample the previous stage's
  // old value; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= PWM_IN;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise      = sync2 & ~sync3;
  assign fall      = ~sync2 & sync3;
  assign edge_seen = rise | fall;

  // ---------------------------------------------------------------------------
  // Edge-gap counter. Saturates at TIMEOUT so the stuck event fires once per
  // quiet stretch. An edge in the same cycle suppresses the event (rise wins).
  // ---------------------------------------------------------------------------
  assign timeout_evt = !edge_seen && (gap == GAP_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      gap <= '0;
    end else if (edge_seen) begin
      gap <= '0;
    end else if (gap != GAP_W'(TIMEOUT)) begin
      gap <= gap + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tracking FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state is given a default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (rise) next_state = S_HIGH;
      S_HIGH:  if (fall) next_state = S_LOW;
      S_LOW:   if (rise) next_state = S_HIGH;
      default: next_state = S_IDLE;
    endcase
    if (timeout_evt) next_state = S_IDLE;
  end

  // A rise seen in S_LOW closes a full high+low period.
  assign period_done = (state == S_LOW) && rise;

  // ---------------------------------------------------------------------------
  // Period / high-time counters. The rise cycle counts as 1, so at the next
  // rise cnt equals H+L and at the fall it equals H.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt      <= '0;
      high_cnt <= '0;
    end else begin
      if (timeout_evt) begin
        cnt <= '0;
      end else if (rise) begin
        cnt <= CNT_W'(1);
      end else if (state != S_IDLE && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      if (state == S_HIGH && fall) high_cnt <= cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring divider: (high*100) / period, one quotient bit per cycle, MSB
  // first. The divisor starts shifted left by 6 and moves right each step.
  // A snapshot is accepted when idle, or on the final iteration so that
  // back-to-back work starts the following cycle.
  // ---------------------------------------------------------------------------
  assign div_last = div_busy && (div_iter == 3'd6);
  assign accept   = period_done && (!div_busy || div_last);
  assign q_bit    = (rem >= dsr);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      div_busy    <= 1'b0;
      div_iter    <= '0;
      rem         <= '0;
      dsr         <= '0;
      quo         <= '0;
      snap_period <= '0;
      snap_high   <= '0;
    end else if (timeout_evt) begin
      div_busy <= 1'b0;
      div_iter <= '0;
    end else if (accept) begin
      snap_period <= cnt;
      snap_high   <= high_cnt;
      rem         <= {7'd0, high_cnt} * DIV_W'(100);
      dsr         <= {1'b0, cnt, 6'd0};
      quo         <= '0;
      div_iter    <= '0;
      div_busy    <= 1'b1;
    end else if (div_busy) begin
      if (q_bit) rem <= rem - dsr;
      quo      <= {quo[5:0], q_bit};
      dsr      <= dsr >> 1;
      div_iter <= div_iter + 3'd1;
      div_busy <= !div_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers. The final quotient bit is taken straight from the last
  // comparison so the result lands the cycle after the 7th iteration.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      Duty     <= '0;
      Period   <= '0;
      HighTime <= '0;
      Valid    <= 1'b0;
      Stuck    <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      Valid <= 1'b0;
      if (timeout_evt) begin
        Stuck    <= 1'b1;
        Duty     <= sync2 ? 7'd100 : 7'd0;
        Period   <= '0;
        HighTime <= '0;
        Valid    <= 1'b1;
      end else if (div_last) begin
        Duty     <= {quo[5:0], q_bit};
        Period   <= snap_period;
        HighTime <= snap_high;
        Valid    <= 1'b1;
      end
      if (rise) Stuck <= 1'b0;
      if (period_done && div_busy && !div_last) Overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//   Scoreboard bench for pwm_capture (CNT_W=16, TIMEOUT=200). The stimulus
//   tasks drive PWM_IN on falling edges and, from the pin-level waveform,
//   predict every Valid event (values and the cycle it must appear in). A
//   monitor pops and compares on each Valid.
//
//   Timing model relative to the posedge counter value c at which a pin edge
//   is driven: two synchroniser stages put the detect cycle at c+2; a
//   measurement Valid is seen at c+10 (detect + latch + 7 iterations); a
//   timeout Valid at c+3+TIMEOUT after the last edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pwm_capture;

  localparam int TO = 200;

  typedef struct {
    int duty;
    int period;
    int high;
    int cyc;
    bit stuck;
  } exp_t;

  logic        CLK;
  logic        RST_n;
  logic        PWM_IN;
  logic [6:0]  Duty;
  logic [15:0] Period;
  logic [15:0] HighTime;
  logic        Valid;
  logic        Stuck;
  logic        Overrun;

  pwm_capture #(.CNT_W(16), .TIMEOUT(TO)) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .PWM_IN   (PWM_IN),
    .Duty     (Duty),
    .Period   (Period),
    .HighTime (HighTime),
    .Valid    (Valid),
    .Stuck    (Stuck),
    .Overrun  (Overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  // Model state
  bit m_started = 0;
  int m_rise    = 0;
  int m_high    = 0;
  int m_acc     = -1000;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0;
    m_rise    = 0;
    m_high    = 0;
    m_acc     = -1000;
  endtask

  task automatic model_edge(input bit v, input int c);
    int p;
    exp_t e;
    if (v) begin
      if (m_started) begin
        p = c - m_rise;
        if (c - m_acc >= 7) begin
          e.duty   = (m_high * 100) / p;
          e.period = p;
          e.high   = m_high;
          e.cyc    = c + 10;
          e.stuck  = 1'b0;
          sb.push_back(e);
          m_acc = c;
        end
      end
      m_started = 1;
      m_rise    = c;
    end else begin
      m_high = c - m_rise;
    end
  endtask

  task automatic model_timeout(input bit v, input int c);
    exp_t e;
    e.duty   = v ? 100 : 0;
    e.period = 0;
    e.high   = 0;
    e.cyc    = c + 3 + TO;
    e.stuck  = 1'b1;
    sb.push_back(e);
    m_started = 0;
    m_acc     = -1000;
  endtask

  // Drive level v for n cycles; every call must toggle the pin.
  task automatic drive(input bit v, input int n);
    @(negedge CLK);
    PWM_IN = v;
    model_edge(v, cyc);
    if (n > TO) model_timeout(v, cyc);
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic pulse(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge CLK);
    check("drain_empty", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every Valid must match the oldest prediction.
  always @(negedge CLK) begin
    exp_t e;
    if (RST_n === 1'b1 && Valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("duty",      Duty,     e.duty);
        check("period",    Period,   e.period);
        check("high_time", HighTime, e.high);
        check("valid_cyc", cyc,      e.cyc);
        check("stuck",     Stuck,    e.stuck);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    PWM_IN = 1'b0;
    RST_n  = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_duty",    Duty,     0);
    check("rst_period",  Period,   0);
    check("rst_high",    HighTime, 0);
    check("rst_valid",   Valid,    0);
    check("rst_stuck",   Stuck,    0);
    check("rst_overrun", Overrun,  0);
    RST_n = 1'b1;

    // 25% duty, period 100; first result after the second rise
    repeat (3) pulse(25, 75);
    // near-full duty and 50%
    pulse(99, 1);
    pulse(50, 50);

    // low gap exactly TIMEOUT: rise and timeout coincide, rise wins
    pulse(10, TO);
    drive(1'b1, 10);
    check("stuck_boundary", Stuck, 0);
    // low gap one past TIMEOUT: stuck low, Duty 0
    drive(1'b0, TO + 1);
    // truncation case 100/3 -> 33, measured straight after the timeout
    pulse(1, 2);
    pulse(30, 30);

    // stuck high after a valid period, then recovery
    pulse(25, 75);
    drive(1'b1, 300);
    drive(1'b0, 40);
    check("stuck_held", Stuck, 1);
    drive(1'b1, 20);
    check("stuck_clear", Stuck, 0);
    drive(1'b0, 80);
    // stuck low after a valid period
    drive(1'b1, 40);
    drive(1'b0, 300);
    drain();
    check("overrun_pre", Overrun, 0);

    // 5-cycle periods overrun the divider; accepted snapshots stay exact
    pulse(25, 75);
    for (int i = 0; i < 8; i++) pulse(1 + i % 3, 4 - i % 3);
    pulse(30, 70);
    pulse(30, 70);
    drive(1'b1, 10);
    drain();
    check("overrun_set", Overrun, 1);

    // reset during the 4th divider iteration
    drive(1'b0, 20);
    drive(1'b1, 7);
    RST_n = 1'b0;
    #1;
    check("mid_rst_duty",    Duty,     0);
    check("mid_rst_period",  Period,   0);
    check("mid_rst_high",    HighTime, 0);
    check("mid_rst_valid",   Valid,    0);
    check("mid_rst_stuck",   Stuck,    0);
    check("mid_rst_overrun", Overrun,  0);
    sb.delete();
    model_reset();
    PWM_IN = 1'b0;
    repeat (5) @(negedge CLK);
    RST_n = 1'b1;
    pulse(20, 30);
    pulse(20, 30);
    drive(1'b1, 10);
    drive(1'b0, 5);
    drain();
    check("overrun_after_rst", Overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
